// File: rtl/uart_pkg.sv
// Shared constants for the UART receiver: parity-type encodings, rx state codes
// and parity helpers. Parity support is compiled in only with UART_RX_PARITY_EN.
package uart_pkg;

  // parity_type encodings; any other value means the frame has no parity bit
  localparam logic [1:0] ParityOdd  = 2'b00;
  localparam logic [1:0] ParityEven = 2'b01;

  // rx state enumeration (plain constants so older tools and dumps stay readable)
  typedef logic [2:0] rx_state_e;
  localparam rx_state_e StIdle   = 3'd0;
  localparam rx_state_e StStart  = 3'd1;
  localparam rx_state_e StData   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam rx_state_e StParity = 3'd3;
`endif
  localparam rx_state_e StStop   = 3'd4;
  localparam rx_state_e StBreak  = 3'd5;

`ifdef UART_RX_PARITY_EN
  // True when the frame carries a parity bit for this parity type
  function automatic logic parity_in_frame(input logic [1:0] ptype);
    return (ptype == ParityOdd) || (ptype == ParityEven);
  endfunction

  // Parity bit a correct transmitter would have sent for this data byte
  function automatic logic expected_parity(input logic [1:0] ptype, input logic [7:0] data);
    return (ptype == ParityOdd) ? ~(^data) : (^data);
  endfunction
`endif

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops reset to 1
// so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the raw line through two flops; synchronous active-low reset to idle-high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional parity bit, one stop bit.
// Parity handling is present only when UART_RX_PARITY_EN is defined; otherwise
// parity_type is ignored and parity_error is tied low.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  input  logic [1:0] parity_type,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  // Down-counter reload values; a sample is taken when the counter reaches zero
  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

  logic            rx_s;
  logic            tick;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      data_out_q, data_out_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic [1:0]      ptype_q, ptype_d;
  logic            par_bit_q, par_bit_d;
  logic            perr_q, perr_d;
`else
  logic            unused_parity_type;
  assign unused_parity_type = ^parity_type;
`endif

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx_in),
    .q_o   (rx_s)
  );

  assign tick = (cnt_q == '0);

  // Next-state logic for the frame FSM, sample counter and result registers
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    ferr_d     = ferr_q;
`ifdef UART_RX_PARITY_EN
    ptype_d    = ptype_q;
    par_bit_d  = par_bit_q;
    perr_d     = perr_q;
`endif
    case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          cnt_d   = CntHalf;
        end
      end
      StStart: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx_s) begin
          // Start bit gone by mid-bit: treat as a glitch
          state_d = StIdle;
        end else begin
          state_d   = StData;
          cnt_d     = CntFull;
          bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
          ptype_d   = parity_type;
`endif
        end
      end
      StData: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shreg_d   = {rx_s, shreg_q[7:1]};
          cnt_d     = CntFull;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = parity_in_frame(ptype_q) ? StParity : StStop;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          par_bit_d = rx_s;
          cnt_d     = CntFull;
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          valid_d    = 1'b1;
          data_out_d = shreg_q;
          ferr_d     = ~rx_s;
`ifdef UART_RX_PARITY_EN
          perr_d     = parity_in_frame(ptype_q) &&
                       (par_bit_q != expected_parity(ptype_q, shreg_q));
`endif
          cnt_d      = '0;
          state_d    = rx_s ? StIdle : StBreak;
        end
      end
      StBreak: begin
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      ptype_q    <= ParityOdd;
      par_bit_q  <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
      ptype_q    <= ptype_d;
      par_bit_q  <= par_bit_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign data_out      = data_out_q;
  assign data_valid    = valid_q;
  assign framing_error = ferr_q;
  assign busy          = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign parity_error  = perr_q;
`else
  assign parity_error  = 1'b0;
`endif

endmodule
